// File: rtl/mem_lsu_if.sv
// Signal bundle for the load/store unit: execute-stage request/response
// plus the data-bus request/grant/rvalid handshake.
// The master modport is the LSU itself; slave is the pipeline and bus around it.
interface mem_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    // Execute-stage request and response
    logic              lsu_mem_rd;
    logic              lsu_mem_wr;
    logic [2:0]        lsu_op;
    logic [ADDR_W-1:0] lsu_addr;
    logic [XLEN-1:0]   lsu_wdata;
    logic [XLEN-1:0]   lsu_rdata;
    logic              lsu_rvalid;
    logic              lsu_st_done;
    logic              lsu_stall;
    logic              lsu_ld_misalign;
    logic              lsu_st_misalign;

    // Data bus
    logic              dbus_req;
    logic              dbus_we;
    logic [ADDR_W-1:0] dbus_addr;
    logic [XLEN-1:0]   dbus_wdata;
    logic [3:0]        dbus_be;
    logic              dbus_gnt;
    logic              dbus_rvalid;
    logic [XLEN-1:0]   dbus_rdata;

    modport master (
        input  lsu_mem_rd, lsu_mem_wr, lsu_op, lsu_addr, lsu_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata,
        output lsu_rdata, lsu_rvalid, lsu_st_done, lsu_stall,
        output lsu_ld_misalign, lsu_st_misalign,
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be
    );

    modport slave (
        output lsu_mem_rd, lsu_mem_wr, lsu_op, lsu_addr, lsu_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata,
        input  lsu_rdata, lsu_rvalid, lsu_st_done, lsu_stall,
        input  lsu_ld_misalign, lsu_st_misalign,
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit, memory side. Captures one EX-stage request, runs a
// req/gnt (+ rvalid for loads) data-bus transaction, formats load data,
// flags misaligned accesses and stalls the pipeline while busy.
module mem_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       rst,
    mem_lsu_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              st_done_q, st_done_d;
    logic              ld_mis_q, ld_mis_d;
    logic              st_mis_q, st_mis_d;

    logic              req_is_load;
    logic              req_misalign;
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_fmt;
    logic [3:0]        be;
    logic [XLEN-1:0]   wdata_rep;

    // Decode the incoming request: loads win when both strobes are high;
    // funct3[1:0] gives the access size (01 half, 1x word).
    always_comb begin
        req_is_load  = bus.lsu_mem_rd;
        req_misalign = (bus.lsu_op[1:0] == 2'b01 && bus.lsu_addr[0]) ||
                       (bus.lsu_op[1] && bus.lsu_addr[1:0] != 2'b00);
    end

    // Lane steering for the captured request and load-data formatting.
    always_comb begin
        ld_shift = bus.dbus_rdata >> {addr_q[1:0], 3'b000};
        case (op_q)
            3'b000:  ld_fmt = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_fmt = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_fmt = ld_shift;
        endcase
        case (op_q[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {(XLEN/8){wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << {addr_q[1], 1'b0};
                wdata_rep = {(XLEN/16){wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Next-state, captured-request and bus/handshake outputs.
    // NOTE: every signal written here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        st_done_d = 1'b0;
        ld_mis_d  = 1'b0;
        st_mis_d  = 1'b0;

        bus.dbus_req   = 1'b0;
        bus.dbus_we    = 1'b0;
        bus.dbus_addr  = '0;
        bus.dbus_wdata = '0;
        bus.dbus_be    = 4'b0000;
        bus.lsu_stall  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.lsu_mem_rd || bus.lsu_mem_wr) begin
                    if (req_misalign) begin
                        ld_mis_d = req_is_load;
                        st_mis_d = !req_is_load;
                    end else begin
                        op_d    = bus.lsu_op;
                        addr_d  = bus.lsu_addr;
                        wdata_d = bus.lsu_wdata;
                        we_d    = !req_is_load;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                bus.dbus_req   = 1'b1;
                bus.dbus_we    = we_q;
                bus.dbus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                bus.dbus_wdata = wdata_rep;
                bus.dbus_be    = be;
                bus.lsu_stall  = !(bus.dbus_gnt && we_q);
                if (bus.dbus_gnt) begin
                    st_done_d = we_q;
                    state_d   = we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                bus.lsu_stall = !bus.dbus_rvalid;
                if (bus.dbus_rvalid) begin
                    rdata_d  = ld_fmt;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            st_done_q <= 1'b0;
            ld_mis_q  <= 1'b0;
            st_mis_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            st_done_q <= st_done_d;
            ld_mis_q  <= ld_mis_d;
            st_mis_q  <= st_mis_d;
        end
    end

    // Registered pulses and load result to the pipeline.
    always_comb begin
        bus.lsu_rdata       = rdata_q;
        bus.lsu_rvalid      = rvalid_q;
        bus.lsu_st_done     = st_done_q;
        bus.lsu_ld_misalign = ld_mis_q;
        bus.lsu_st_misalign = st_mis_q;
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases, wait states, reset
// mid-transaction and randomized traffic against an arithmetic reference model.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mem_lsu_if bus ();

    mem_lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes from funct3.
    function automatic int size_of(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
        int sz = size_of(op);
        int v  = ((1 << sz) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
        int sz = size_of(op);
        if (sz == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] mem);
        int          sz = size_of(op);
        logic [31:0] v  = mem >> (8 * (addr % 4));
        logic [31:0] m  = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        v = v & m;
        if (!op[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    // One full request from the pipeline side with configurable grant and
    // rvalid delays; optional noise drives ignored inputs while busy.
    task automatic do_txn(input string nm, input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata, input int gw,
                          input int rw, input logic [31:0] mem, input bit noise);
        bit          is_ld = rd;
        bit          mis   = (addr % size_of(op)) != 0;
        logic [3:0]  ebe   = model_be(op, addr);
        logic [31:0] ewd   = model_wdata(op, wdata);
        logic [31:0] erd   = model_load(op, addr, mem);
        logic [31:0] ead   = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        bus.lsu_mem_rd = rd;
        bus.lsu_mem_wr = wr;
        bus.lsu_op     = op;
        bus.lsu_addr   = addr;
        bus.lsu_wdata  = wdata;
        @(negedge clk);
        bus.lsu_mem_rd = 1'b0;
        bus.lsu_mem_wr = 1'b0;
        if (mis) begin
            total++;
            if (bus.lsu_ld_misalign !== is_ld || bus.lsu_st_misalign !== !is_ld) begin
                bad++;
                $display("FAIL %s misalign pulse: got ld=%b st=%b want ld=%b st=%b",
                         nm, bus.lsu_ld_misalign, bus.lsu_st_misalign, is_ld, !is_ld);
            end
            total++;
            if (bus.dbus_req !== 1'b0 || bus.lsu_stall !== 1'b0) begin
                bad++;
                $display("FAIL %s misalign idle: got req=%b stall=%b want 0 0",
                         nm, bus.dbus_req, bus.lsu_stall);
            end
            @(negedge clk);
            total++;
            if (bus.lsu_ld_misalign !== 1'b0 || bus.lsu_st_misalign !== 1'b0 || bus.dbus_req !== 1'b0) begin
                bad++;
                $display("FAIL %s misalign one-shot: got ld=%b st=%b req=%b want 0 0 0",
                         nm, bus.lsu_ld_misalign, bus.lsu_st_misalign, bus.dbus_req);
            end
            return;
        end
        for (int i = 0; i <= gw; i++) begin
            bus.dbus_gnt = (i == gw);
            if (noise) begin
                bus.dbus_rvalid = 1'($urandom);
                bus.dbus_rdata  = $urandom;
                bus.lsu_mem_rd  = 1'($urandom);
                bus.lsu_mem_wr  = 1'($urandom);
                bus.lsu_op      = 3'($urandom);
                bus.lsu_addr    = $urandom;
                bus.lsu_wdata   = $urandom;
            end
            #1;
            total++;
            if (bus.dbus_req !== 1'b1 || bus.dbus_we !== !is_ld || bus.dbus_addr !== ead ||
                bus.dbus_be !== ebe) begin
                bad++;
                $display("FAIL %s bus req cyc%0d: got req=%b we=%b addr=%h be=%b want 1 %b %h %b",
                         nm, i, bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_be, !is_ld, ead, ebe);
            end
            if (!is_ld) begin
                total++;
                if (bus.dbus_wdata !== ewd) begin
                    bad++;
                    $display("FAIL %s store wdata cyc%0d: got %h want %h", nm, i, bus.dbus_wdata, ewd);
                end
            end
            total++;
            if (bus.lsu_stall !== !(i == gw && !is_ld)) begin
                bad++;
                $display("FAIL %s stall in req cyc%0d: got %b want %b", nm, i, bus.lsu_stall,
                         !(i == gw && !is_ld));
            end
            @(negedge clk);
        end
        bus.dbus_gnt    = 1'b0;
        bus.dbus_rvalid = 1'b0;
        bus.lsu_mem_rd  = 1'b0;
        bus.lsu_mem_wr  = 1'b0;
        if (!is_ld) begin
            #1;
            total++;
            if (bus.lsu_st_done !== 1'b1 || bus.dbus_req !== 1'b0 || bus.lsu_stall !== 1'b0) begin
                bad++;
                $display("FAIL %s store done: got done=%b req=%b stall=%b want 1 0 0",
                         nm, bus.lsu_st_done, bus.dbus_req, bus.lsu_stall);
            end
            @(negedge clk);
            total++;
            if (bus.lsu_st_done !== 1'b0) begin
                bad++;
                $display("FAIL %s store done one-shot: got %b want 0", nm, bus.lsu_st_done);
            end
            return;
        end
        for (int j = 0; j <= rw; j++) begin
            bus.dbus_rvalid = (j == rw);
            bus.dbus_rdata  = (j == rw) ? mem : $urandom;
            if (noise) bus.dbus_gnt = 1'($urandom);
            #1;
            total++;
            if (bus.lsu_stall !== (j != rw) || bus.dbus_req !== 1'b0 || bus.lsu_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL %s resp wait cyc%0d: got stall=%b req=%b rvalid=%b want %b 0 0",
                         nm, j, bus.lsu_stall, bus.dbus_req, bus.lsu_rvalid, (j != rw));
            end
            @(negedge clk);
        end
        bus.dbus_rvalid = 1'b0;
        bus.dbus_gnt    = 1'b0;
        #1;
        total++;
        if (bus.lsu_rvalid !== 1'b1 || bus.lsu_rdata !== erd || bus.lsu_stall !== 1'b0) begin
            bad++;
            $display("FAIL %s load result: got rvalid=%b rdata=%h stall=%b want 1 %h 0",
                     nm, bus.lsu_rvalid, bus.lsu_rdata, bus.lsu_stall, erd);
        end
        @(negedge clk);
        total++;
        if (bus.lsu_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL %s rvalid one-shot: got %b want 0", nm, bus.lsu_rvalid);
        end
    endtask

    task automatic test_reset();
        bus.lsu_mem_rd  = 1'b0;
        bus.lsu_mem_wr  = 1'b0;
        bus.lsu_op      = 3'b000;
        bus.lsu_addr    = '0;
        bus.lsu_wdata   = '0;
        bus.dbus_gnt    = 1'b0;
        bus.dbus_rvalid = 1'b0;
        bus.dbus_rdata  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_wdata, bus.dbus_be} !== '0) begin
            bad++;
            $display("FAIL reset dbus: got req=%b we=%b addr=%h wdata=%h be=%b want all 0",
                     bus.dbus_req, bus.dbus_we, bus.dbus_addr, bus.dbus_wdata, bus.dbus_be);
        end
        total++;
        if ({bus.lsu_rdata, bus.lsu_rvalid, bus.lsu_st_done, bus.lsu_stall,
             bus.lsu_ld_misalign, bus.lsu_st_misalign} !== '0) begin
            bad++;
            $display("FAIL reset lsu: got rdata=%h rv=%b sd=%b stall=%b lm=%b sm=%b want all 0",
                     bus.lsu_rdata, bus.lsu_rvalid, bus.lsu_st_done, bus.lsu_stall,
                     bus.lsu_ld_misalign, bus.lsu_st_misalign);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_txn("lw_0x100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
        total++;
        if (bus.lsu_rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL lw_0x100 rdata: got %h want deadbeef", bus.lsu_rdata);
        end
        do_txn("lb_0x103", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h8011_2233, 1'b0);
        total++;
        if (bus.lsu_rdata !== 32'hFFFF_FF80) begin
            bad++;
            $display("FAIL lb_0x103 rdata: got %h want ffffff80", bus.lsu_rdata);
        end
        do_txn("lbu_0x103", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h8011_2233, 1'b0);
        total++;
        if (bus.lsu_rdata !== 32'h0000_0080) begin
            bad++;
            $display("FAIL lbu_0x103 rdata: got %h want 00000080", bus.lsu_rdata);
        end
        do_txn("lh_0x102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0);
        do_txn("lhu_0x102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h8001_7FFF, 1'b0);
        do_txn("sh_0x102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 0, 0, 32'h0, 1'b0);
        do_txn("sb_0x101", 1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_005A, 0, 0, 32'h0, 1'b0);
        do_txn("rd_wr_both", 1'b1, 1'b1, 3'b010, 32'h204, 32'h1111_1111, 0, 1, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_misalign();
        do_txn("lw_0x101", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
        do_txn("lh_0x103", 1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 0, 0, 32'h0, 1'b0);
        do_txn("sw_0x102", 1'b0, 1'b1, 3'b010, 32'h102, 32'h5555_AAAA, 0, 0, 32'h0, 1'b0);
        do_txn("sh_0x101", 1'b0, 1'b1, 3'b001, 32'h101, 32'h5555_AAAA, 0, 0, 32'h0, 1'b0);
    endtask

    task automatic test_wait_states();
        do_txn("sw_gnt_wait3", 1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_0123, 3, 0, 32'h0, 1'b0);
        do_txn("lw_gnt_wait3", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 3, 2, 32'h7654_3210, 1'b0);
    endtask

    task automatic test_ignore_idle();
        @(negedge clk);
        bus.dbus_gnt    = 1'b1;
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 32'hFFFF_FFFF;
        #1;
        total++;
        if (bus.dbus_req !== 1'b0 || bus.lsu_stall !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore comb: got req=%b stall=%b want 0 0", bus.dbus_req, bus.lsu_stall);
        end
        @(negedge clk);
        bus.dbus_gnt    = 1'b0;
        bus.dbus_rvalid = 1'b0;
        total++;
        if (bus.lsu_rvalid !== 1'b0 || bus.lsu_st_done !== 1'b0 || bus.dbus_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore pulses: got rv=%b sd=%b req=%b want 0 0 0",
                     bus.lsu_rvalid, bus.lsu_st_done, bus.dbus_req);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.lsu_mem_rd = 1'b1;
        bus.lsu_op     = 3'b010;
        bus.lsu_addr   = 32'h200;
        @(negedge clk);
        bus.lsu_mem_rd = 1'b0;
        bus.dbus_gnt   = 1'b1;
        @(negedge clk);
        bus.dbus_gnt = 1'b0;
        #1;
        total++;
        if (bus.lsu_stall !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid in resp: got stall=%b want 1", bus.lsu_stall);
        end
        rst = 1'b1;
        @(negedge clk);
        rst             = 1'b0;
        bus.dbus_rvalid = 1'b1;
        bus.dbus_rdata  = 32'h1234_5678;
        #1;
        total++;
        if (bus.dbus_req !== 1'b0 || bus.lsu_stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid after reset: got req=%b stall=%b want 0 0", bus.dbus_req, bus.lsu_stall);
        end
        @(negedge clk);
        bus.dbus_rvalid = 1'b0;
        total++;
        if (bus.lsu_rvalid !== 1'b0 || bus.lsu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid late rvalid: got rv=%b rdata=%h want 0 0", bus.lsu_rvalid, bus.lsu_rdata);
        end
        @(negedge clk);
        total++;
        if (bus.lsu_rvalid !== 1'b0 || bus.dbus_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid settle: got rv=%b req=%b want 0 0", bus.lsu_rvalid, bus.dbus_req);
        end
    endtask

    task automatic test_random();
        logic [2:0] ld_ops[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] st_ops[3] = '{3'b000, 3'b001, 3'b010};
        for (int n = 0; n < 80; n++) begin
            int          kind = $urandom_range(0, 9);
            logic        rd   = (kind <= 4) || (kind == 9);
            logic        wr   = (kind >= 5);
            logic [2:0]  op   = rd ? ld_ops[$urandom_range(0, 4)] : st_ops[$urandom_range(0, 2)];
            logic [31:0] addr = $urandom;
            if ($urandom_range(0, 9) < 7) addr = addr & ~(32'(size_of(op)) - 32'd1);
            do_txn($sformatf("rand%0d", n), rd, wr, op, addr, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_misalign();
        test_wait_states();
        test_ignore_idle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
